router_ctrl_fsm: RTL
====================

Name: router_ctrl_fsm

Overview:
- Packet-level controller for the 1x3 router.
- Sequences the input register block and the synchronizer through each packet: address decode, header load, payload load, FIFO-full stall, parity load and parity check.
- Sits between the source interface (pkt_valid, header address bits) and the register/synchronizer datapath.
- Generates all datapath strobes as Moore outputs and back-pressures the source with busy.

Parameters:
- PKT_CNT_W, 8, width of the optional completed-packet counter (used only with ROUTER_PKT_CNT_EN).

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source asserts for header plus payload bytes; deasserts before parity byte
- data_in  in  2  header address bits [1:0]; 0/1/2 = port, 3 = invalid
- fifo_full  in  1  full flag of the currently selected FIFO (from synchronizer)
- fifo_empty_0/1/2  in  1 each  FIFO empty flags
- soft_reset_0/1/2  in  1 each  per-port soft resets (from synchronizer)
- parity_done  in  1  register block has loaded the parity byte
- low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
- detect_add  out  1  high in DECODE_ADDRESS
- lfd_state  out  1  high in LOAD_FIRST_DATA
- ld_state  out  1  high in LOAD_DATA
- laf_state  out  1  high in LOAD_AFTER_FULL
- full_state  out  1  high in FIFO_FULL_STATE
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR
- write_enb_reg  out  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA
- pkt_count  out  PKT_CNT_W  completed packets (only with ROUTER_PKT_CNT_EN)

Behaviour:
- Reset (synchronous, active-high):
  - state = DECODE_ADDRESS; addr_q = 2'b11.
  - Outputs after reset: detect_add=1, all other strobes 0, busy=0.
- Outputs:
  - Pure Moore decode of state; no output depends combinationally on inputs.
  - Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state/rst_int_reg is high in its own state.
  - LOAD_PARITY and WAIT_TILL_EMPTY assert none of those six strobes.
- addr_q:
  - Loaded from data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=3.
  - Held otherwise.
- Soft reset:
  - If soft_reset_<addr_q>=1 and state != DECODE_ADDRESS, next state = DECODE_ADDRESS.
  - Overrides every transition below; reset overrides soft reset.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid & data_in=k (k<3) & fifo_empty_k -> LOAD_FIRST_DATA.
    - pkt_valid & data_in=k & ~fifo_empty_k -> WAIT_TILL_EMPTY.
    - Otherwise stay; data_in=3 is ignored.
  - WAIT_TILL_EMPTY: fifo_empty_<addr_q> -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly 1 cycle).
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else ~pkt_valid -> LOAD_PARITY.
    - else stay. fifo_full has priority over a simultaneous pkt_valid fall.
  - FIFO_FULL_STATE: ~fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- Timing and encoding:
  - Minimum packet latency, empty FIFO, 1 payload byte: DECODE -> LFD -> LD -> LP -> CPE -> DECODE, 5 cycles.
  - State encoding is binary, 3 bits, 8 states. The unused code is impossible (all 8 codes are assigned). Any X-free illegal value recovers to DECODE_ADDRESS.

Optional Feature:
- ROUTER_PKT_CNT_EN
- Defined:
  - pkt_count port exists. It increments by 1 on every CHECK_PARITY_ERROR -> DECODE_ADDRESS transition, and on LOAD_AFTER_FULL -> DECODE_ADDRESS via parity_done.
  - Wraps 2^PKT_CNT_W-1 -> 0.
  - Cleared by reset, not by soft reset.
  - A soft-reset abort does not count.
- Undefined: no counter and no pkt_count port; all other behaviour identical.

Decomposition:
- Package router_pkg:
  - state enum/localparams: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
  - port address constants ADDR_P0=0, ADDR_P1=1, ADDR_P2=2, ADDR_INVALID=3.
- No sub-module: next-state logic, address latch and optional counter sit in one module.

Test Plan:
- Reset held 2 cycles, then pkt_valid=1, data_in=1, fifo_empty_1=1 -> sequence DECODE, LFD, LD. Drop pkt_valid after 3 payload cycles -> LP, CPE, DECODE; write_enb_reg high for 4 cycles; busy high in LFD/LP/CPE only.
- pkt_valid=1, data_in=2, fifo_empty_2=0 for 5 cycles, then 1 -> WAIT_TILL_EMPTY for 5 cycles with busy=1, then LFD.
- In LOAD_DATA assert fifo_full for 3 cycles -> FIFO_FULL_STATE 3 cycles (full_state=1). Then release with low_pkt_valid=1, parity_done=0 -> LAF -> LP; repeat with parity_done=1 -> LAF -> DECODE.
- soft_reset_0 pulse while in WAIT_TILL_EMPTY on addr 0 -> DECODE_ADDRESS next cycle. soft_reset_1 pulse in the same state -> no effect.
- pkt_valid=1 with data_in=3 for 4 cycles -> remains DECODE_ADDRESS, detect_add=1, addr_q stays 2'b11.
- With ROUTER_PKT_CNT_EN and PKT_CNT_W=2, send 5 complete packets -> pkt_count 1, 2, 3, 0, 1. An aborted packet (soft reset) leaves the count unchanged.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router controller: FSM state codes and header port addresses.
package router_pkg;

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
    localparam logic [2:0] LOAD_PARITY        = 3'd5;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

    localparam logic [1:0] ADDR_P0      = 2'd0;
    localparam logic [1:0] ADDR_P1      = 2'd1;
    localparam logic [1:0] ADDR_P2      = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    // Pick the per-port flag for an address; the invalid address selects nothing.
    function automatic logic port_sel(input logic [1:0] addr, input logic [2:0] flags);
        logic r;
        case (addr)
            ADDR_P0: r = flags[0];
            ADDR_P1: r = flags[1];
            ADDR_P2: r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-level controller for the 1x3 router; all datapath strobes are Moore decodes of state.
// Optional completed-packet counter (and its PKT_CNT_W parameter) enabled by ROUTER_PKT_CNT_EN.
module router_ctrl_fsm
    import router_pkg::*;
`ifdef ROUTER_PKT_CNT_EN
#(
    parameter int PKT_CNT_W = 8
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
`ifdef ROUTER_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0] pkt_count
`endif
);

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [2:0] empties;
    logic [2:0] soft_resets;
    logic       hdr_empty;
    logic       cur_empty;
    logic       soft_abort;

    assign empties     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_resets = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_empty   = port_sel(data_in, empties);
    assign cur_empty   = port_sel(addr_q, empties);
    assign soft_abort  = port_sel(addr_q, soft_resets) && (state_q != DECODE_ADDRESS);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != ADDR_INVALID) begin
                    addr_d  = data_in;
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY:    if (cur_empty) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // A soft reset of the port being served abandons the packet from any state.
        if (soft_abort) state_d = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= ADDR_INVALID;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ROUTER_PKT_CNT_EN
    logic                 pkt_done;
    logic [PKT_CNT_W-1:0] cnt_q, cnt_d;

    // Only orderly returns to DECODE_ADDRESS count as completed packets.
    assign pkt_done = !soft_abort &&
                      ((state_q == CHECK_PARITY_ERROR && !fifo_full) ||
                       (state_q == LOAD_AFTER_FULL && parity_done));

    always_comb begin
        cnt_d = cnt_q;
        if (pkt_done) cnt_d = cnt_q + PKT_CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign pkt_count = cnt_q;
`endif

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule
